// File: rtl/keypad_ascii_scanner.sv
// keypad_ascii_scanner: 4x4 matrix keypad scanner with debounce and ASCII translation.
// Build option KEYPAD_DEBOUNCE_EN: when defined, presses and releases need DEBOUNCE
// stable synced samples; when undefined, a single sample decides and no counter exists.
module keypad_ascii_scanner #(
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 8
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       en,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [7:0] ascii,
    output logic [2:0] status,
    output logic       key_strb
);

    typedef enum logic [1:0] {IDLE, SCAN, PRESS, RELEASE} state_t;

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [127:0] KEYMAP = "123A456B789C*0#D";

    state_t           state;
    logic [3:0]       sync1;
    logic [3:0]       rows_s;
    logic [1:0]       col;
    logic [DIV_W-1:0] div;
    logic             key_ready;
    logic [1:0]       row_idx;
    logic             single_key;
    logic [7:0]       key_code;

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
    logic [DB_W-1:0] db;
    logic [3:0]      code;
`endif

    // Column drive and status are pure decodes of the state registers.
    assign cols   = (state == IDLE) ? 4'b1111 : ~(4'b0001 << col);
    assign status = {key_ready, state != IDLE, (state == IDLE) || (state == SCAN)};

    // Row index of the lowest set synced row bit, one-hot test, and the mapped character.
    always_comb begin
        row_idx    = rows_s[0] ? 2'd0 : rows_s[1] ? 2'd1 : rows_s[2] ? 2'd2 : 2'd3;
        single_key = (rows_s != 4'd0) && ((rows_s & (rows_s - 4'd1)) == 4'd0);
        key_code   = KEYMAP[{~{row_idx, col}, 3'b000} +: 8];
    end

    // Row synchronizer plus the scan/press/release state machine; en=0 always wins.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            sync1     <= 4'd0;
            rows_s    <= 4'd0;
            col       <= 2'd0;
            div       <= '0;
            key_ready <= 1'b0;
            ascii     <= 8'h00;
            key_strb  <= 1'b0;
`ifdef KEYPAD_DEBOUNCE_EN
            db        <= '0;
            code      <= 4'd0;
`endif
        end else begin
            sync1    <= rows;
            rows_s   <= sync1;
            key_strb <= 1'b0;
            if (!en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        state <= SCAN;
                        col   <= 2'd0;
                        div   <= '0;
                    end
                    SCAN: begin
                        if (rows_s != 4'd0) begin
                            state <= PRESS;
`ifdef KEYPAD_DEBOUNCE_EN
                            code  <= rows_s;
                            db    <= '0;
`endif
                        end else if (div == DIV_LAST) begin
                            col <= col + 2'd1;
                            div <= '0;
                        end else begin
                            div <= div + DIV_W'(1);
                        end
                    end
                    PRESS: begin
`ifdef KEYPAD_DEBOUNCE_EN
                        if (rows_s == 4'd0) begin
                            state <= SCAN;
                            div   <= '0;
                        end else if (rows_s != code) begin
                            code <= rows_s;
                            db   <= '0;
                        end else if (db == DB_LAST) begin
                            state <= RELEASE;
                            db    <= '0;
                            if (single_key) begin
                                ascii     <= key_code;
                                key_ready <= 1'b1;
                                key_strb  <= 1'b1;
                            end
                        end else begin
                            db <= db + DB_W'(1);
                        end
`else
                        if (rows_s == 4'd0) begin
                            state <= SCAN;
                            div   <= '0;
                        end else begin
                            state <= RELEASE;
                            if (single_key) begin
                                ascii     <= key_code;
                                key_ready <= 1'b1;
                                key_strb  <= 1'b1;
                            end
                        end
`endif
                    end
                    RELEASE: begin
`ifdef KEYPAD_DEBOUNCE_EN
                        if (rows_s != 4'd0) begin
                            db <= '0;
                        end else if (db == DB_LAST) begin
                            state <= SCAN;
                            col   <= col + 2'd1;
                            div   <= '0;
                            db    <= '0;
                        end else begin
                            db <= db + DB_W'(1);
                        end
`else
                        if (rows_s == 4'd0) begin
                            state <= SCAN;
                            col   <= col + 2'd1;
                            div   <= '0;
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_ascii_scanner.sv
// tb_keypad_ascii_scanner: directed bench for keypad_ascii_scanner with a keypad matrix model.
module tb_keypad_ascii_scanner;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  rows;
    logic [3:0]  raw = 4'd0;
    logic [15:0] keys = 16'd0;
    logic [3:0]  cols;
    logic [7:0]  ascii;
    logic [2:0]  status;
    logic        key_strb;
    logic [7:0]  last_ascii = 8'h00;
    int          tests = 0;
    int          fails = 0;
    int          strobes = 0;

    keypad_ascii_scanner #(.SCAN_DIV(4), .DEBOUNCE(4)) dut (
        .clk(clk), .nrst(nrst), .en(en), .rows(rows),
        .cols(cols), .ascii(ascii), .status(status), .key_strb(key_strb)
    );

    always #5 clk = ~clk;

    // A pressed key at (r,c) pulls row r high only while column c is driven low.
    always_comb begin
        rows = raw;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !cols[c]) rows[r] = 1'b1;
    end

    always @(posedge clk) if (key_strb === 1'b1) strobes++;

    task automatic wait_col(input logic [3:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && cols === target; i++) @(negedge clk);
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (cols === target) ok = 1'b1;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL wait_col: cols=%b never reached %b", cols, target);
        end
    endtask

    task automatic test_reset;
        int bad;
        int s0;
        nrst = 1'b0; en = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (cols !== 4'b1111) begin fails++; $display("FAIL reset_cols: got %b want 1111", cols); end
        tests++; if (ascii !== 8'h00) begin fails++; $display("FAIL reset_ascii: got %h want 00", ascii); end
        tests++; if (status !== 3'b001) begin fails++; $display("FAIL reset_status: got %b want 001", status); end
        tests++; if (key_strb !== 1'b0) begin fails++; $display("FAIL reset_strb: got %b want 0", key_strb); end
        nrst = 1'b1;
        s0 = strobes; bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (cols !== 4'b1111 || status !== 3'b001 || ascii !== 8'h00) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL idle_hold: %0d bad cycles, want 0", bad); end
        tests++; if (strobes != s0) begin fails++; $display("FAIL idle_strb: %0d strobes, want 0", strobes - s0); end
    endtask

    task automatic test_scan;
        logic [3:0] exp;
        en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            exp = ~(4'b0001 << ((k / 4) % 4));
            tests++;
            if (cols !== exp) begin fails++; $display("FAIL scan_cols[%0d]: got %b want %b", k, cols, exp); end
            if (k == 10) begin
                tests++;
                if (status !== 3'b011) begin fails++; $display("FAIL scan_status: got %b want 011", status); end
            end
        end
    endtask

    task automatic test_key(input int r, input int c, input logic [7:0] exp);
        bit ok;
        bit found;
        int s0;
        logic [3:0] nxt;
        wait_col(~(4'b0001 << c), ok);
        keys[r*4+c] = 1'b1;
        s0 = strobes;
        repeat (30) @(negedge clk);
        tests++; if (strobes - s0 != 1) begin fails++; $display("FAIL key%0d%0d_strb: %0d strobes want 1", r, c, strobes - s0); end
        tests++; if (ascii !== exp) begin fails++; $display("FAIL key%0d%0d_ascii: got %h want %h", r, c, ascii, exp); end
        tests++; if (status !== 3'b110) begin fails++; $display("FAIL key%0d%0d_held: got %b want 110", r, c, status); end
        last_ascii = exp;
        keys = 16'd0;
        found = 1'b0;
        nxt = ~(4'b0001 << ((c + 1) % 4));
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (status[0] === 1'b1) found = 1'b1;
        end
        tests++; if (!found) begin fails++; $display("FAIL key%0d%0d_release: status=%b never left hold", r, c, status); end
        tests++; if (cols !== nxt) begin fails++; $display("FAIL key%0d%0d_resume: cols=%b want %b", r, c, cols, nxt); end
        tests++; if (status !== 3'b111) begin fails++; $display("FAIL key%0d%0d_status: got %b want 111", r, c, status); end
        repeat (2) @(negedge clk);
        tests++; if (strobes - s0 != 1) begin fails++; $display("FAIL key%0d%0d_norepeat: %0d strobes want 1", r, c, strobes - s0); end
    endtask

    task automatic test_glitch;
        bit ok;
        int s0;
        int want;
        wait_col(4'b1110, ok);
        s0 = strobes;
        raw = 4'h1;
        repeat (2) @(negedge clk);
        raw = 4'h0;
        repeat (20) @(negedge clk);
`ifdef KEYPAD_DEBOUNCE_EN
        want = 0;
`else
        want = 1;
        last_ascii = 8'h31;
`endif
        tests++; if (strobes - s0 != want) begin fails++; $display("FAIL glitch_strb: %0d strobes want %0d", strobes - s0, want); end
        tests++; if (ascii !== last_ascii) begin fails++; $display("FAIL glitch_ascii: got %h want %h", ascii, last_ascii); end
    endtask

    task automatic test_ghost;
        bit ok;
        int s0;
        wait_col(4'b1101, ok);
        keys[0*4+1] = 1'b1;
        keys[1*4+1] = 1'b1;
        s0 = strobes;
        repeat (30) @(negedge clk);
        tests++; if (strobes != s0) begin fails++; $display("FAIL ghost_strb: %0d strobes want 0", strobes - s0); end
        tests++; if (ascii !== last_ascii) begin fails++; $display("FAIL ghost_ascii: got %h want %h", ascii, last_ascii); end
        tests++; if (status !== 3'b110) begin fails++; $display("FAIL ghost_held: got %b want 110", status); end
        keys = 16'd0;
        repeat (15) @(negedge clk);
        tests++; if (status !== 3'b111) begin fails++; $display("FAIL ghost_release: got %b want 111", status); end
    endtask

    task automatic test_en_abort;
        bit ok;
        int s0;
        wait_col(4'b1101, ok);
        keys[1*4+1] = 1'b1;
        s0 = strobes;
        repeat (3) @(negedge clk);
        tests++; if (status !== 3'b110) begin fails++; $display("FAIL abort_press: got %b want 110", status); end
        en = 1'b0;
        @(negedge clk);
        tests++; if (cols !== 4'b1111) begin fails++; $display("FAIL abort_cols: got %b want 1111", cols); end
        tests++; if (status !== 3'b101) begin fails++; $display("FAIL abort_status: got %b want 101", status); end
        repeat (10) @(negedge clk);
        tests++; if (strobes != s0) begin fails++; $display("FAIL abort_strb: %0d strobes want 0", strobes - s0); end
        tests++; if (ascii !== last_ascii) begin fails++; $display("FAIL abort_ascii: got %h want %h", ascii, last_ascii); end
        keys = 16'd0;
    endtask

    task automatic test_reset_mid;
        en = 1'b1;
        repeat (6) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        tests++; if (cols !== 4'b1111) begin fails++; $display("FAIL mid_cols: got %b want 1111", cols); end
        tests++; if (ascii !== 8'h00) begin fails++; $display("FAIL mid_ascii: got %h want 00", ascii); end
        tests++; if (status !== 3'b001) begin fails++; $display("FAIL mid_status: got %b want 001", status); end
        tests++; if (key_strb !== 1'b0) begin fails++; $display("FAIL mid_strb: got %b want 0", key_strb); end
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_scan;
        test_key(0, 0, 8'h31);
        test_key(2, 2, 8'h39);
        test_key(3, 0, 8'h2A);
        test_glitch;
        test_ghost;
        test_en_abort;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
